// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, SR/Cause field layout and packing helpers.
// Pure declarations, no logic or latency; no handshake involved.
// Imported by the arbiter and the controller so both agree on the field positions.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT = 5'd9;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] sr_pack(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_MSB:SR_IM_LSB] = s.im;
        w[SR_EXL_BIT]          = s.exl;
        w[SR_IE_BIT]           = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_pack(input cause_t c);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD_BIT]                = c.bd;
        w[CAUSE_IP_MSB:CAUSE_IP_LSB]   = c.ip;
        w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 bundle: MEM-stage exception inputs, mtc0/mfc0/eret access and redirect outputs.
// Wires only, zero latency; no backpressure, exc_req is a single-cycle flush/redirect strobe.
// master = pipeline side, slave = CP0 controller.
interface cp0_exc_ctrl_if;
    logic        m_valid;
    logic [31:0] pc_m;
    logic [4:0]  exc_code_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output m_valid, pc_m, exc_code_m, bd_m, hw_int,
        output cp0_we, cp0_addr, cp0_wdata, eret_m,
        input  cp0_rdata, exc_req, handler_pc, epc_out
    );

    modport slave (
        input  m_valid, pc_m, exc_code_m, bd_m, hw_int,
        input  cp0_we, cp0_addr, cp0_wdata, eret_m,
        output cp0_rdata, exc_req, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_irq_arb.sv
// Interrupt vs. internal-exception arbitration for the MEM-stage instruction.
// Purely combinational, zero latency; no backpressure, m_valid=0 simply holds requests off.
// Interrupts win and report ExcCode 0; EXL=1 masks everything.
module cp0_irq_arb
    import cp0_pkg::*;
(
    input  logic       m_valid_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [5:0] im_i,
    input  logic [5:0] hw_int_i,
    input  logic [4:0] exc_code_i,
    output logic       exc_req_o,
    output logic [4:0] sel_code_o
);

    logic int_req;
    logic exc_int;

    assign int_req    = m_valid_i & ie_i & ~exl_i & (|(hw_int_i & im_i));
    assign exc_int    = m_valid_i & ~exl_i & (exc_code_i != 5'd0);
    assign exc_req_o  = int_req | exc_int;
    assign sel_code_o = int_req ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId (+ Count when CP0_COUNT_EN is defined).
// exc_req and mfc0 data are combinational (0 cycles); register updates land on the next clk edge.
// No backpressure: exc_req is a one-cycle strobe, and an exception edge discards any mtc0 that cycle.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h4255_4141
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_ctrl_if.slave  cp0
);

    sr_t         sr_q, sr_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        arb_req;
    logic        exc_req;
    logic [4:0]  sel_code;
    logic [31:0] epc_base;
    logic [31:0] rdata;

    cp0_irq_arb u_arb (
        .m_valid_i  (cp0.m_valid),
        .ie_i       (sr_q.ie),
        .exl_i      (sr_q.exl),
        .im_i       (sr_q.im),
        .hw_int_i   (cp0.hw_int),
        .exc_code_i (cp0.exc_code_m),
        .exc_req_o  (arb_req),
        .sel_code_o (sel_code)
    );

    // Gated by reset so the flush strobe drops the moment reset asserts.
    assign exc_req  = arb_req & reset;
    assign epc_base = cp0.bd_m ? (cp0.pc_m - 32'd4) : cp0.pc_m;

    always_comb begin
        sr_d       = sr_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        cause_d.ip = cp0.hw_int;
        if (exc_req) begin
            sr_d.exl    = 1'b1;
            cause_d.exc = sel_code;
            cause_d.bd  = cp0.bd_m;
            epc_d       = epc_base & ~32'd3;
        end else begin
            if (cp0.eret_m) begin
                sr_d.exl = 1'b0;
            end
            if (cp0.cp0_we) begin
                case (cp0.cp0_addr)
                    REG_SR: begin
                        sr_d.im  = cp0.cp0_wdata[SR_IM_MSB:SR_IM_LSB];
                        sr_d.exl = cp0.cp0_wdata[SR_EXL_BIT];
                        sr_d.ie  = cp0.cp0_wdata[SR_IE_BIT];
                    end
                    REG_EPC: epc_d = cp0.cp0_wdata & ~32'd3;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 32'd1;
        if (cp0.cp0_we && !exc_req && cp0.cp0_addr == REG_COUNT) begin
            count_d = cp0.cp0_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    logic [31:0] count_q;
    assign count_q = '0;
`endif

    always_comb begin
        rdata = '0;
        case (cp0.cp0_addr)
            REG_COUNT: rdata = count_q;
            REG_SR:    rdata = sr_pack(sr_q);
            REG_CAUSE: rdata = cause_pack(cause_q);
            REG_EPC:   rdata = epc_q;
            REG_PRID:  rdata = PRID_VAL;
            default:   rdata = '0;
        endcase
    end

    assign cp0.cp0_rdata  = rdata;
    assign cp0.exc_req    = exc_req;
    assign cp0.handler_pc = HANDLER_PC;
    assign cp0.epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: expected values queued as stimulus is applied, popped as outputs are sampled.
module tb_cp0_exc_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(
        .HANDLER_PC (32'h0000_4180),
        .PRID_VAL   (32'h4255_4141)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cp0   (bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic expect_v(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h required=queued_entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h required=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string t, input logic [4:0] a, input logic [31:0] e);
        expect_v(t, e);
        bus.cp0_addr = a;
        #1;
        check_v(bus.cp0_rdata);
    endtask

    task automatic reqchk(input string t, input logic e);
        expect_v(t, {31'd0, e});
        #1;
        check_v({31'd0, bus.exc_req});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_valid    = 1'b0;
        bus.pc_m       = '0;
        bus.exc_code_m = '0;
        bus.bd_m       = 1'b0;
        bus.hw_int     = '0;
        bus.cp0_we     = 1'b0;
        bus.cp0_addr   = '0;
        bus.cp0_wdata  = '0;
        bus.eret_m     = 1'b0;
        reset          = 1'b1;
        #1 reset = 1'b0;
        #1;
        rdchk("rst_sr", 5'd12, 32'h0);
        rdchk("rst_cause", 5'd13, 32'h0);
        rdchk("rst_epc", 5'd14, 32'h0);
        reqchk("rst_req", 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        rdchk("prid", 5'd15, 32'h4255_4141);
        rdchk("unmapped_rd", 5'd3, 32'h0);
        expect_v("handler_pc", 32'h0000_4180);
        check_v(bus.handler_pc);

        // Overflow exception, then identical stimulus blocked by EXL
        bus.m_valid = 1'b1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3010;
        reqchk("ovf_req", 1'b1);
        tick();
        reqchk("ovf_blocked", 1'b0);
        bus.m_valid = 1'b0; bus.exc_code_m = 5'd0;
        rdchk("ovf_sr", 5'd12, 32'h0000_0002);
        rdchk("ovf_cause", 5'd13, 32'h0000_0030);
        rdchk("ovf_epc", 5'd14, 32'h0000_3010);
        tick();
        bus.eret_m = 1'b1;
        tick();
        bus.eret_m = 1'b0;
        rdchk("eret_sr", 5'd12, 32'h0);

        // mtc0 SR: old value visible during the write cycle
        bus.cp0_we = 1'b1; bus.cp0_wdata = 32'h0000_0401;
        rdchk("sr_nobypass", 5'd12, 32'h0);
        tick();
        bus.cp0_we = 1'b0;
        rdchk("sr_write", 5'd12, 32'h0000_0401);

        // Delay-slot interrupt
        bus.hw_int = 6'b000001; bus.bd_m = 1'b1; bus.pc_m = 32'h3024; bus.m_valid = 1'b1;
        reqchk("ds_req", 1'b1);
        tick();
        bus.m_valid = 1'b0; bus.bd_m = 1'b0;
        rdchk("ds_cause", 5'd13, 32'h8000_0400);
        rdchk("ds_epc", 5'd14, 32'h0000_3020);
        expect_v("ds_epc_out", 32'h0000_3020);
        check_v(bus.epc_out);

        // Interrupt beats RI exception
        bus.eret_m = 1'b1;
        tick();
        bus.eret_m = 1'b0;
        bus.m_valid = 1'b1; bus.exc_code_m = 5'd10; bus.pc_m = 32'h3100;
        reqchk("prio_req", 1'b1);
        tick();
        bus.m_valid = 1'b0; bus.exc_code_m = 5'd0;
        rdchk("prio_cause", 5'd13, 32'h0000_0400);
        rdchk("prio_epc", 5'd14, 32'h0000_3100);
        bus.eret_m = 1'b1;
        tick();
        bus.eret_m = 1'b0;

        // Pending interrupt held off while m_valid=0
        for (int i = 0; i < 3; i++) begin
            reqchk("holdoff", 1'b0);
            tick();
        end
        bus.m_valid = 1'b1; bus.pc_m = 32'h3104;
        reqchk("holdoff_take", 1'b1);
        tick();
        bus.m_valid = 1'b0;
        rdchk("holdoff_sr", 5'd12, 32'h0000_0403);
        rdchk("holdoff_epc", 5'd14, 32'h0000_3104);

        // mtc0 EPC drops the low bits, old value read during the write
        bus.cp0_we = 1'b1; bus.cp0_wdata = 32'h3047;
        rdchk("epc_nobypass", 5'd14, 32'h0000_3104);
        tick();
        bus.cp0_we = 1'b0;
        rdchk("epc_write", 5'd14, 32'h0000_3044);

        // eret with EXL=1 reopens requests
        bus.m_valid = 1'b1; bus.eret_m = 1'b1;
        reqchk("eret_blocked", 1'b0);
        tick();
        bus.eret_m = 1'b0;
        // mtc0 SR colliding with an exception edge is lost
        bus.cp0_we = 1'b1; bus.cp0_wdata = 32'h0; bus.pc_m = 32'h3200;
        rdchk("eret_sr_clr", 5'd12, 32'h0000_0401);
        reqchk("eret_reenable", 1'b1);
        tick();
        bus.cp0_we = 1'b0; bus.m_valid = 1'b0;
        rdchk("mtc0_lost_sr", 5'd12, 32'h0000_0403);
        rdchk("mtc0_lost_epc", 5'd14, 32'h0000_3200);
        bus.eret_m = 1'b1;
        tick();
        bus.eret_m = 1'b0; bus.hw_int = 6'b0;

        // Writes to an unmapped register are ignored
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd3; bus.cp0_wdata = 32'hDEAD_BEEF;
        tick();
        bus.cp0_we = 1'b0;
        rdchk("unmapped_wr", 5'd3, 32'h0);

`ifdef CP0_COUNT_EN
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'hFFFF_FFFE;
        tick();
        bus.cp0_we = 1'b0;
        rdchk("count_load", 5'd9, 32'hFFFF_FFFE);
        tick();
        rdchk("count_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        rdchk("count_wrap", 5'd9, 32'h0);
`else
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'h1234_5678;
        tick();
        bus.cp0_we = 1'b0;
        rdchk("count_absent", 5'd9, 32'h0);
        tick();
        rdchk("count_absent2", 5'd9, 32'h0);
`endif

        // Asynchronous reset mid-cycle with a live exception request
        bus.hw_int = 6'b000001; bus.m_valid = 1'b1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3300;
        reqchk("pre_reset_req", 1'b1);
        reset = 1'b0;
        rdchk("mid_rst_sr", 5'd12, 32'h0);
        rdchk("mid_rst_cause", 5'd13, 32'h0);
        rdchk("mid_rst_epc", 5'd14, 32'h0);
        reqchk("mid_rst_req", 1'b0);
        tick();
        bus.m_valid = 1'b0; bus.exc_code_m = 5'd0;
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
